cdb_arbiter: RTL

Writeback stage directly downstream of the ALU execute unit and its sibling functional units. Buffers each unit's completed `data_bus_package_t` in a small per-source FIFO. Each cycle, grants one buffered result round-robin onto the single registered common data bus (CDB) consumed by the ROB, reservation stations, RAT and physical register file. Flushes all in-flight results on a mispredict.

---
 rtl/rv32i_types.sv | 25 ++
 rtl/cdb_src_fifo.sv | 90 +++++++++
 rtl/cdb_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I core types.
// Holds the result package broadcast on the common data bus and the
// CDB source enumeration used by the writeback arbiter.
package rv32i_types;

    // Result package produced by every functional unit and broadcast on the CDB.
    typedef struct packed {
        logic        execute_valid;   // package carries a live result
        logic [5:0]  rob_idx;         // reorder-buffer slot of the producing instruction
        logic [5:0]  phys_rd;         // destination physical register
        logic [4:0]  arch_rd;         // destination architectural register
        logic [31:0] val;             // result value
        logic        branch_mismatch; // branch resolved against its prediction
        logic [31:0] branch_target;   // resolved target for a mispredicted branch
    } data_bus_package_t;

    localparam int unsigned CDB_N_SRC = 3;

    typedef enum logic [1:0] {
        CDB_ALU,
        CDB_MULDIV,
        CDB_LSU
    } cdb_src_e;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO for the CDB arbiter.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   flush       - synchronous clear of count and pointers (beats push/pop)
//   push        - write push_pkg at the tail
//   push_pkg    - package to enqueue
//   pop         - drop the head entry
//   full/empty  - registered occupancy flags
//   head        - entry at the read pointer (undefined content when empty)
//
// DEPTH must be a power of two so the pointers wrap naturally.
module cdb_src_fifo
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  data_bus_package_t push_pkg,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output data_bus_package_t head
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    data_bus_package_t mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Push while full is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_pkg;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus writeback arbiter.
//
// Buffers each functional unit's result in a small FIFO and grants one
// buffered result per cycle, round-robin, onto the registered CDB. A flush
// discards every in-flight result.
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   src_valid  - per-source result strobe
//   src_pkg    - per-source result package
//   src_ready  - per-source FIFO has room (registered state only)
//   flush      - mispredict squash, synchronous, highest priority
//   cdb_valid  - registered CDB beat strobe
//   cdb_pkg    - registered CDB package; execute_valid mirrors cdb_valid
//   cdb_src    - index of the unit that produced the current CDB package
//
// Build option CDB_BYPASS_EN: a source whose FIFO is empty competes with its
// live input in the same cycle and, on winning, skips the FIFO (one-cycle
// latency). Without it every result goes through the FIFO (two cycles).
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned N_SRC = CDB_N_SRC,
    parameter int unsigned DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_SRC-1:0]                    src_valid,
    input  data_bus_package_t [N_SRC-1:0]       src_pkg,
    output logic [N_SRC-1:0]                    src_ready,
    input  logic                                flush,
    output logic                                cdb_valid,
    output data_bus_package_t                   cdb_pkg,
    output logic [$clog2(N_SRC)-1:0]            cdb_src
);

    localparam int unsigned SrcW = $clog2(N_SRC);

    logic [N_SRC-1:0]              fifo_full;
    logic [N_SRC-1:0]              fifo_empty;
    data_bus_package_t [N_SRC-1:0] fifo_head;
    logic [N_SRC-1:0]              fifo_push;
    logic [N_SRC-1:0]              fifo_pop;

    logic [N_SRC-1:0] cand;
    logic             grant_found;
    logic [SrcW-1:0]  grant_idx;
    logic             grant_bypass;
    int unsigned      idx;

    logic              cdb_valid_q, cdb_valid_d;
    data_bus_package_t cdb_pkg_q, cdb_pkg_d;
    logic [SrcW-1:0]   cdb_src_q, cdb_src_d;
    logic [SrcW-1:0]   rr_ptr_q, rr_ptr_d;

    for (genvar g = 0; g < N_SRC; g++) begin : g_fifo
        cdb_src_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .push     (fifo_push[g]),
            .push_pkg (src_pkg[g]),
            .pop      (fifo_pop[g]),
            .full     (fifo_full[g]),
            .empty    (fifo_empty[g]),
            .head     (fifo_head[g])
        );
    end

    assign src_ready = ~fifo_full;

    // Round-robin search over candidates starting at rr_ptr.
    always_comb begin
`ifdef CDB_BYPASS_EN
        // A live input only competes when its FIFO is empty, so a queued head
        // always beats the same source's bypass and order is preserved.
        cand = ~fifo_empty | (fifo_empty & src_valid);
`else
        cand = ~fifo_empty;
`endif
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            idx = (32'(rr_ptr_q) + k) % N_SRC;
            if (!grant_found && cand[idx]) begin
                grant_found = 1'b1;
                grant_idx   = SrcW'(idx);
            end
        end
`ifdef CDB_BYPASS_EN
        grant_bypass = grant_found && fifo_empty[grant_idx];
`else
        grant_bypass = 1'b0;
`endif
    end

    always_comb begin
        fifo_push = '0;
        fifo_pop  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            // A winning bypass input is consumed directly and never queued.
            fifo_push[i] = src_valid[i] && src_ready[i] && !flush
                           && !(grant_bypass && (grant_idx == SrcW'(i)));
            fifo_pop[i]  = grant_found && !grant_bypass && !flush
                           && (grant_idx == SrcW'(i));
        end
    end

    always_comb begin
        cdb_valid_d = 1'b0;
        cdb_pkg_d   = cdb_pkg_q;
        cdb_src_d   = cdb_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else if (grant_found) begin
            cdb_valid_d = 1'b1;
            cdb_pkg_d   = grant_bypass ? src_pkg[grant_idx] : fifo_head[grant_idx];
            cdb_pkg_d.execute_valid = 1'b1;
            cdb_src_d   = grant_idx;
            rr_ptr_d    = (grant_idx == SrcW'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_q <= 1'b0;
            cdb_pkg_q   <= '0;
            cdb_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_pkg_q   <= cdb_pkg_d;
            cdb_src_q   <= cdb_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_src   = cdb_src_q;

    // An idle CDB still holds the last package, but must not look live.
    always_comb begin
        cdb_pkg               = cdb_pkg_q;
        cdb_pkg.execute_valid = cdb_valid_q;
    end

    // A unit must not present a result its FIFO cannot take; it would be lost.
    for (genvar g = 0; g < N_SRC; g++) begin : g_proto_chk
        a_no_push_when_full: assert property (
            @(posedge clk) disable iff (!rst_n) !(src_valid[g] && !src_ready[g])
        );
    end

endmodule
